// File: rtl/sfifo_multich_wr_engine.sv
// sfifo_multich_wr_engine
//   FX3 GPIF-II slave-FIFO write master for up to four upstream word streams.
//   Channels are served round-robin, one burst (USB packet) at a time; channel i
//   writes socket faddr = i. Short frames are committed with PKTEND on the word
//   carrying ch_last. A full BURST_LEN packet is auto-committed by the FX3.
//
//   Optional feature macro: SFIFO_TIMEOUT_FLUSH_EN
//     defined   : an idle counter in BURST forces a lone-PKTEND commit after
//                 TIMEOUT_CYC idle cycles, or releases the grant if nothing was
//                 written yet.
//     undefined : BURST waits indefinitely for the granted channel.
//
// Ports
//   clk, reset        bus clock, asynchronous active-high reset
//   ch_data           NUM_CH packed words, channel i at [i*DATA_W +: DATA_W]
//   ch_valid/ch_last  per-channel valid and end-of-frame marker
//   ch_ready          per-channel accept (only the granted channel, only in BURST)
//   flag_rdy          FX3 watermark flag of the addressed socket (async, 1 flop sync)
//   slcs_n, slwr_n, pktend_n, faddr, fdata, fdata_oe   registered FX3 pins
//   busy              high whenever the engine is not idle
//   pkt_cnt           committed packets, wraps at 16 bits
module sfifo_multich_wr_engine #(
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 4,
    parameter int BURST_LEN   = 256,
    parameter int SETTLE_CYC  = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH-1:0]        ch_last,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic                     flag_rdy,
    output logic                     slcs_n,
    output logic                     slwr_n,
    output logic                     pktend_n,
    output logic [1:0]               faddr,
    output logic [DATA_W-1:0]        fdata,
    output logic                     fdata_oe,
    output logic                     busy,
    output logic [15:0]              pkt_cnt
);

    localparam int WC_W = $clog2(BURST_LEN + 1);
    localparam int ST_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [WC_W-1:0]   LAST_WC = WC_W'(BURST_LEN - 1);
    localparam logic [NUM_CH-1:0] ONE_CH  = NUM_CH'(1);

    // Elaboration-time parameter range checks
    if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) begin : g_bad_data_w
        $error("DATA_W must be 8, 16 or 32");
    end
    if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_num_ch
        $error("NUM_CH must be 1..4");
    end
    if (BURST_LEN < 2 || BURST_LEN > 4096) begin : g_bad_burst
        $error("BURST_LEN must be 2..4096");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, ADDR, SETTLE, BURST, COMMIT, GAP} state_t;

    state_t            state;
    logic [1:0]        grant;
    logic [1:0]        last_grant;
    logic [ST_W-1:0]   settle_cnt;
    logic [WC_W-1:0]   word_cnt;
    logic              flag_q;
`ifdef SFIFO_TIMEOUT_FLUSH_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]   idle_cnt;
`endif

    // Unpack the channel bus so the granted word is a simple array select
    logic [DATA_W-1:0] ch_word [NUM_CH];
    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_word[i] = ch_data[i*DATA_W +: DATA_W];
    end

    // Round-robin search: walking offsets from NUM_CH down to 1 lets the
    // smallest offset after last_grant overwrite the others.
    logic       rr_hit;
    logic [1:0] rr_idx;
    always_comb begin
        int c;
        rr_hit = 1'b0;
        rr_idx = '0;
        c      = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            c = (int'(last_grant) + k) % NUM_CH;
            if (ch_valid[c]) begin
                rr_hit = 1'b1;
                rr_idx = 2'(c);
            end
        end
    end

    logic hs;
    assign hs = (state == BURST) && ch_valid[grant] && ch_ready[grant];

    // Single FSM; every FX3-facing output is registered together with the
    // transition that produces it, so the pins reflect the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= 2'(NUM_CH - 1);
            settle_cnt <= '0;
            word_cnt   <= '0;
            flag_q     <= 1'b0;
`ifdef SFIFO_TIMEOUT_FLUSH_EN
            idle_cnt   <= '0;
`endif
            slcs_n     <= 1'b1;
            slwr_n     <= 1'b1;
            pktend_n   <= 1'b1;
            faddr      <= '0;
            fdata      <= '0;
            fdata_oe   <= 1'b0;
            ch_ready   <= '0;
            busy       <= 1'b0;
            pkt_cnt    <= '0;
        end else begin
            flag_q   <= flag_rdy;
            slwr_n   <= 1'b1;
            pktend_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (rr_hit) begin
                        grant      <= rr_idx;
                        last_grant <= rr_idx;
                        faddr      <= rr_idx;
                        state      <= ADDR;
                        slcs_n     <= 1'b0;
                        fdata_oe   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ADDR: begin
                    settle_cnt <= ST_W'(SETTLE_CYC);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    // The last settle cycle doubles as the first flag sample;
                    // a low flag keeps re-sampling with the grant held.
                    if (settle_cnt > ST_W'(1)) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end else if (flag_q) begin
                        state    <= BURST;
                        word_cnt <= '0;
                        ch_ready <= ONE_CH << grant;
`ifdef SFIFO_TIMEOUT_FLUSH_EN
                        idle_cnt <= '0;
`endif
                    end
                end
                BURST: begin
                    if (hs) begin
                        fdata    <= ch_word[grant];
                        slwr_n   <= 1'b0;
                        word_cnt <= word_cnt + 1'b1;
`ifdef SFIFO_TIMEOUT_FLUSH_EN
                        idle_cnt <= '0;
`endif
                        if (ch_last[grant] || word_cnt == LAST_WC) begin
                            // A last word that also fills the packet is a
                            // full packet: the FX3 commits it without PKTEND.
                            pktend_n <= !(ch_last[grant] && word_cnt != LAST_WC);
                            ch_ready <= '0;
                            state    <= GAP;
                        end
                    end
`ifdef SFIFO_TIMEOUT_FLUSH_EN
                    else if (!ch_valid[grant]) begin
                        if (idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                            ch_ready <= '0;
                            if (word_cnt != '0) begin
                                pktend_n <= 1'b0;
                                state    <= COMMIT;
                            end else begin
                                // Nothing written: give the bus back.
                                state    <= IDLE;
                                slcs_n   <= 1'b1;
                                fdata_oe <= 1'b0;
                                busy     <= 1'b0;
                            end
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
`endif
                end
                COMMIT: begin
                    state <= GAP;
                end
                GAP: begin
                    pkt_cnt  <= pkt_cnt + 16'd1;
                    state    <= IDLE;
                    slcs_n   <= 1'b1;
                    fdata_oe <= 1'b0;
                    busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfifo_multich_wr_engine.sv
// Bench for sfifo_multich_wr_engine (DATA_W=16, NUM_CH=4, BURST_LEN=4,
// SETTLE_CYC=3, TIMEOUT_CYC=16). Per-channel word lists feed the DUT; a
// transaction-level model follows the FX3 bus and predicts data order,
// packet boundaries, PKTEND and the packet count.
module tb_sfifo_multich_wr_engine;
    localparam int DW = 16, NCH = 4, BL = 4, SC = 3, TO = 16, MAXW = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NCH*DW-1:0] ch_data = '0;
    logic [NCH-1:0]    ch_valid = '0, ch_last = '0, ch_ready;
    logic              flag_rdy = 1'b1;
    logic              slcs_n, slwr_n, pktend_n, fdata_oe, busy;
    logic [1:0]        faddr;
    logic [DW-1:0]     fdata;
    logic [15:0]       pkt_cnt;

    sfifo_multich_wr_engine #(.DATA_W(DW), .NUM_CH(NCH), .BURST_LEN(BL),
                              .SETTLE_CYC(SC), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .ch_data(ch_data), .ch_valid(ch_valid),
        .ch_last(ch_last), .ch_ready(ch_ready), .flag_rdy(flag_rdy),
        .slcs_n(slcs_n), .slwr_n(slwr_n), .pktend_n(pktend_n), .faddr(faddr),
        .fdata(fdata), .fdata_oe(fdata_oe), .busy(busy), .pkt_cnt(pkt_cnt));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [DW-1:0] w_data [NCH][MAXW];
    bit            w_last [NCH][MAXW];
    int src_len[NCH], lim[NCH], src_idx[NCH], out_idx[NCH];
    bit hs_q[NCH];
    bit rand_gaps = 0, rand_flag = 0;
    int pkt_words, pkt_ch, exp_pkts, lone_pe, n_pe, n_wr;
    int wr_cyc[$], pe_cyc[$], start_ch[$], lone_cyc[$];
    bit prev_cs_low;
    logic [1:0] prev_faddr;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < NCH; c++) begin
            src_len[c] = 0; lim[c] = 0; src_idx[c] = 0; out_idx[c] = 0; hs_q[c] = 0;
        end
        pkt_words = 0; pkt_ch = 0; exp_pkts = 0; lone_pe = 0; n_pe = 0; n_wr = 0;
        wr_cyc.delete(); pe_cyc.delete(); start_ch.delete(); lone_cyc.delete();
        prev_cs_low = 0; prev_faddr = '0;
    endtask

    task automatic add_frame(input int c, input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            w_data[c][src_len[c]] = DW'($urandom);
            w_last[c][src_len[c]] = with_last && (i == n - 1);
            src_len[c]++;
        end
        lim[c] = src_len[c];
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_slcs_n"}, slcs_n, 1);
        check({tag, "_slwr_n"}, slwr_n, 1);
        check({tag, "_pktend_n"}, pktend_n, 1);
        check({tag, "_faddr"}, faddr, 0);
        check({tag, "_fdata"}, fdata, 0);
        check({tag, "_fdata_oe"}, fdata_oe, 0);
        check({tag, "_ch_ready"}, ch_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pkt_cnt"}, pkt_cnt, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; ch_valid = '0; ch_last = '0; ch_data = '0; flag_rdy = 1'b1;
        clear_model();
        @(negedge clk);
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic bit all_done();
        for (int c = 0; c < NCH; c++) if (out_idx[c] != src_len[c]) return 0;
        return 1;
    endfunction

    // One cycle: retire last edge's handshakes, check the bus, drive next inputs.
    task automatic tick();
        int c, n;
        bit last, exp_pe, v;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < NCH; k++) if (hs_q[k]) src_idx[k]++;

        if (slcs_n) begin
            check("idle_pins", {slwr_n, pktend_n, fdata_oe, busy}, 4'b1100);
            check("idle_ready", ch_ready, 0);
            check("pkt_cnt", pkt_cnt, exp_pkts & 16'hFFFF);
        end else begin
            check("active_pins", {fdata_oe, busy}, 2'b11);
            check("ready_only_granted", ch_ready & ~(4'(1) << faddr), 0);
            if (prev_cs_low) check("faddr_stable", faddr, prev_faddr);
        end
        prev_cs_low = !slcs_n;
        prev_faddr  = faddr;

        if (!slwr_n) begin
            c = int'(faddr);
            n_wr++;
            wr_cyc.push_back(cyc);
            check("write_was_accepted", out_idx[c] < src_idx[c], 1);
            last = 0;
            if (out_idx[c] < src_len[c]) begin
                check("fdata", fdata, w_data[c][out_idx[c]]);
                last = w_last[c][out_idx[c]];
            end
            if (pkt_words == 0) start_ch.push_back(c);
            else check("packet_channel", c, pkt_ch);
            pkt_ch = c;
            n = pkt_words + 1;
            exp_pe = last && (n < BL);
            check("pktend_with_write", !pktend_n, exp_pe);
            if (!pktend_n) begin n_pe++; pe_cyc.push_back(cyc); end
            if (last || n == BL) begin pkt_words = 0; exp_pkts++; end
            else pkt_words = n;
            out_idx[c]++;
        end else if (!pktend_n) begin
            lone_pe++;
            lone_cyc.push_back(cyc);
            check("lone_pktend_has_open_packet", pkt_words > 0, 1);
            pkt_words = 0;
            exp_pkts++;
        end

        for (int k = 0; k < NCH; k++) begin
            v = (src_idx[k] < lim[k]) && (!rand_gaps || $urandom_range(3) != 0);
            ch_valid[k] = v;
            ch_last[k]  = v && w_last[k][src_idx[k] % MAXW];
            ch_data[k*DW +: DW] = v ? w_data[k][src_idx[k] % MAXW] : '0;
            hs_q[k] = v && ch_ready[k];
        end
        if (rand_flag) flag_rdy = ($urandom_range(3) != 0);
    endtask

    task automatic run_until_done(input int budget, input string name);
        int k = 0;
        while (!(all_done() && slcs_n) && k < budget) begin tick(); k++; end
        check({name, "_completes_in_budget"}, k < budget, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, rise, k;
        int exp_rr[4] = '{0, 2, 0, 2};
        do_reset();

        // Single channel, 8 words, no last: two full packets on socket 0
        add_frame(0, 8, 0);
        t0 = cyc + 1;
        run_until_done(200, "p1");
        check("p1_writes", wr_cyc.size(), 8);
        check("p1_pktends", n_pe + lone_pe, 0);
        check("p1_pkt_cnt", pkt_cnt, 2);
        if (wr_cyc.size() == 8) begin
            check("p1_first_write_latency", wr_cyc[0] - t0, 1 + 1 + SC + 1);
            check("p1_back_to_back", wr_cyc[3] - wr_cyc[0], 3);
            check("p1_second_burst_start", wr_cyc[4] - wr_cyc[0], 10);
        end

        // Channels 0 and 2 always valid: packets alternate 0,2,0,2
        do_reset();
        add_frame(0, 8, 0);
        add_frame(2, 8, 0);
        run_until_done(300, "p2");
        check("p2_packets", start_ch.size(), 4);
        for (int i = 0; i < 4 && i < start_ch.size(); i++) check("p2_rr_order", start_ch[i], exp_rr[i]);
        check("p2_pkt_cnt", pkt_cnt, 4);

        // Short frame of 3 on channel 1: PKTEND with third write, then idle
        do_reset();
        add_frame(1, 3, 1);
        run_until_done(200, "p3");
        check("p3_pktends", n_pe, 1);
        check("p3_pkt_cnt", pkt_cnt, 1);
        if (wr_cyc.size() == 3 && pe_cyc.size() == 1) begin
            check("p3_pktend_on_third_write", pe_cyc[0], wr_cyc[2]);
            check("p3_idle_after_gap", cyc - wr_cyc[2], 1);
        end

        // flag_rdy held low: no writes, socket 3 held, then resume
        do_reset();
        flag_rdy = 1'b0;
        add_frame(3, 4, 0);
        repeat (25) tick();
        check("p4_no_write_while_flag_low", n_wr, 0);
        check("p4_busy_while_waiting", busy, 1);
        check("p4_faddr_held", faddr, 3);
        flag_rdy = 1'b1;
        rise = cyc;
        run_until_done(200, "p4");
        if (wr_cyc.size() > 0) check("p4_write_after_flag_rise", wr_cyc[0] - rise, 3);
        check("p4_pkt_cnt", pkt_cnt, 1);

        // Two words then an idle stretch, then the final word with last
        do_reset();
        add_frame(0, 3, 1);
        lim[0] = 2;
        k = 0;
        while (out_idx[0] < 2 && k < 100) begin tick(); k++; end
        check("p5_two_words_written", out_idx[0], 2);
        repeat (40) tick();
`ifdef SFIFO_TIMEOUT_FLUSH_EN
        check("p5_lone_pktend", lone_pe, 1);
        if (lone_cyc.size() == 1 && wr_cyc.size() >= 2)
            check("p5_timeout_distance", lone_cyc[0] - wr_cyc[1], TO);
        check("p5_pkt_cnt_after_flush", pkt_cnt, 1);
        check("p5_idle_after_flush", busy, 0);
`else
        check("p5_no_lone_pktend", lone_pe, 0);
        check("p5_still_waiting", busy, 1);
        check("p5_pkt_cnt_waiting", pkt_cnt, 0);
`endif
        lim[0] = 3;
        run_until_done(200, "p5");
        check("p5_pktend_on_last", n_pe, 1);
`ifdef SFIFO_TIMEOUT_FLUSH_EN
        check("p5_pkt_cnt", pkt_cnt, 2);
`else
        check("p5_pkt_cnt", pkt_cnt, 1);
`endif

        // Reset during word 2 of a burst on channel 0
        do_reset();
        add_frame(0, 8, 0);
        k = 0;
        while (out_idx[0] < 2 && k < 100) begin tick(); k++; end
        check("p6_reached_word2", out_idx[0], 2);
        #1 reset = 1'b1;
        #1 check_reset_vals("p6_async");
        do_reset();
        add_frame(0, 4, 0);
        add_frame(1, 4, 0);
        run_until_done(200, "p6");
        check("p6_packets", start_ch.size(), 2);
        if (start_ch.size() == 2) begin
            check("p6_first_after_reset", start_ch[0], 0);
            check("p6_second_after_reset", start_ch[1], 1);
        end

        // Randomized traffic on all channels with gaps and a wobbling flag
        for (int r = 0; r < 2; r++) begin
            do_reset();
            rand_gaps = 1;
            rand_flag = (r == 1);
            for (int c = 0; c < NCH; c++) begin
                while (src_len[c] < 28) add_frame(c, $urandom_range(1, 9), $urandom_range(1) == 1);
                add_frame(c, $urandom_range(1, 5), 1);
            end
            run_until_done(5000, "rand");
            check("rand_pkt_cnt", pkt_cnt, exp_pkts & 16'hFFFF);
            rand_gaps = 0;
            rand_flag = 0;
            flag_rdy = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sfifo_multich_wr_engine.md
# sfifo_multich_wr_engine

Parametrised FX3 slave-FIFO write master. It accepts up to four independent upstream word streams, arbitrates between them round-robin one burst at a time, and drives the FX3 GPIF-II slave-FIFO write pins. Each channel maps to its own socket address. Short packets are committed with PKTEND on end-of-frame, or after an idle timeout. It replaces the fixed single-mode stream-in/partial/ZLP generators in the USB interface top level.

## Interface
Parameters:
- DATA_W, 32, FX3 bus width; legal values 8, 16, 32.
- NUM_CH, 4, upstream channel count, 1..4; channel i uses faddr = i.
- BURST_LEN, 256, words per full USB packet, 2..4096.
- SETTLE_CYC, 3, cycles to wait after an faddr change before sampling flag_rdy.
- TIMEOUT_CYC, 1024, idle cycles inside a burst before a forced short-packet commit.

Ports:
- clk, in, 1, bus clock (100 MHz); PCLK to the FX3 is generated outside this block.
- reset, in, 1, asynchronous, active-high.
- ch_data, in, NUM_CH*DATA_W, channel i occupies bits [i*DATA_W +: DATA_W].
- ch_valid, in, NUM_CH, per-channel word valid.
- ch_last, in, NUM_CH, marks the last word of a frame.
- ch_ready, out, NUM_CH, per-channel accept.
- flag_rdy, in, 1, FX3 watermark flag for the addressed socket; high means at least BURST_LEN words of room. Synchronised internally through one flop.
- slcs_n, out, 1, chip select.
- slwr_n, out, 1, write strobe.
- pktend_n, out, 1, packet end.
- faddr, out, 2, socket address.
- fdata, out, DATA_W, write data.
- fdata_oe, out, 1, tri-state enable for the top-level fdata pad.
- busy, out, 1, high whenever state ≠ IDLE.
- pkt_cnt, out, 16, count of committed packets; wraps at 0xFFFF → 0.

## Operation
- States: IDLE, ADDR, SETTLE, BURST, COMMIT, GAP.
- IDLE:
  - Search round-robin, starting at (last_grant+1) mod NUM_CH, for a channel with ch_valid set.
  - On a hit, latch grant, drive faddr = grant, and go to ADDR.
  - last_grant resets to NUM_CH-1, so channel 0 wins first.
- ADDR → SETTLE: load the settle counter with SETTLE_CYC.
- SETTLE:
  - Count down, then sample the registered flag_rdy.
  - If flag_rdy is high, go to BURST with word count = 0.
  - If flag_rdy is low, stay in SETTLE and re-sample every cycle; grant is not changed.
- BURST:
  - ch_ready[grant] = 1 while word count < BURST_LEN; all other ch_ready bits are 0.
  - Each handshake (valid & ready) registers the data onto fdata with slwr_n = 0 on the next cycle, and increments the word count.
  - Handshake with ch_last: the same output cycle also drives pktend_n = 0 (short packet), then go to GAP.
  - Word count reaches BURST_LEN without ch_last: the FX3 auto-commits, pktend_n stays 1, go to GAP.
  - If ch_last and word count = BURST_LEN occur together, no pktend is issued (full packet).
  - ch_valid low while in BURST: slwr_n = 1 and the idle counter runs. See Configuration.
- COMMIT: entered only from a timeout. Drive one pktend_n = 0 cycle with slwr_n = 1, then go to GAP.
- GAP: one cycle with slwr_n = 1, increment pkt_cnt, then return to IDLE.
- slcs_n = 0 in every state except IDLE.
- fdata_oe = 1 from ADDR through GAP.

## Timing
- Reset values:
  - slcs_n = 1, slwr_n = 1, pktend_n = 1.
  - faddr = 0, fdata = 0, fdata_oe = 0.
  - ch_ready = 0, busy = 0, pkt_cnt = 0.
  - FSM in IDLE.
- All FX3-facing outputs are registered.
- Handshake at edge t produces fdata/slwr_n at t+1. Throughput is one word per cycle.
- Minimum overhead per burst, IDLE to first write: 1 (IDLE) + 1 (ADDR) + SETTLE_CYC + 1 cycles.
- flag_rdy is not checked during BURST; sizing BURST_LEN to the watermark guarantees room.
- Reset asserted mid-burst:
  - All outputs return to their reset values immediately; the partial packet is abandoned with no pktend.
  - Channel data that was in flight is lost; upstream must re-frame.
- NUM_CH = 1: arbitration is a no-op; faddr = 0 permanently.

## Configuration
- SFIFO_TIMEOUT_FLUSH_EN defined:
  - In BURST, the idle counter counts cycles with ch_valid[grant] = 0, and any handshake clears it.
  - At TIMEOUT_CYC with word count > 0, go to COMMIT (pktend alone).
  - At TIMEOUT_CYC with word count = 0, go to IDLE without pktend, so other channels get a turn.
- SFIFO_TIMEOUT_FLUSH_EN undefined: the idle counter logic is absent, and BURST waits indefinitely for the granted channel.

## Test plan
- Single channel, BURST_LEN = 4, 8 words with no last: two bursts of 4 slwr_n pulses at faddr = 0, no pktend, pkt_cnt = 2.
- Channels 0 and 2 both valid continuously: faddr alternates 0, 2, 0, 2 per burst; channel 2 never waits more than one burst.
- ch_last on word 3 with BURST_LEN = 4: pktend_n = 0 coincident with the third slwr_n = 0, then GAP, then IDLE.
- flag_rdy held low for 20 cycles after ADDR: no slwr_n until 1 cycle after flag_rdy rises plus sync delay; faddr stays stable.
- With SFIFO_TIMEOUT_FLUSH_EN and TIMEOUT_CYC = 16, 2 words then idle: a lone pktend_n pulse exactly 16 cycles after the last write. With the macro undefined: no pktend ever.
- reset pulsed during word 2 of a burst: next cycle slwr_n = 1, slcs_n = 1, fdata_oe = 0, pkt_cnt = 0; the next burst starts on channel 0.
